// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download transmitter: FSM state encoding
// and default parameter values.
package ioctl_pkg;

    localparam int unsigned IOCTL_GAP_CYC_DEF = 3;
    localparam int unsigned IOCTL_AW_DEF      = 25;
    localparam int unsigned GAP_CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_TAIL  = 3'd5
    } ioctl_state_e;

    // Reload value that makes the timer expire after gap_cyc cycles (minimum 1).
    function automatic logic [GAP_CNT_W-1:0] gap_reload(input int unsigned gap_cyc);
        return (gap_cyc == 0) ? '0 : GAP_CNT_W'(gap_cyc - 1);
    endfunction

endpackage

// File: rtl/ioctl_gap_timer.sv
// Down-counter that times the idle gap following each ioctl_wr strobe.
module ioctl_gap_timer
    import ioctl_pkg::*;
#(
    parameter int unsigned GAP_CYC = IOCTL_GAP_CYC_DEF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam logic [GAP_CNT_W-1:0] RELOAD = gap_reload(GAP_CYC);

    logic [GAP_CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == '0);

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (count && !expire) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ioctl_tx.sv
// Streams a byte source into the ioctl download port: one write strobe per
// byte, a fixed idle gap after each, honouring receiver back-pressure.
module ioctl_tx
    import ioctl_pkg::*;
#(
    parameter int unsigned GAP_CYC = IOCTL_GAP_CYC_DEF,
    parameter int unsigned AW      = IOCTL_AW_DEF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    index,
    input  logic [AW-1:0] length,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          ioctl_wait,
    output logic          ioctl_download,
    output logic          ioctl_wr,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_index,
    output logic          busy,
    output logic          done
);

    ioctl_state_e  state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_inc;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    index_q, index_d;
    logic          done_q, done_d;
    logic          gap_expire;

    ioctl_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (state_q == ST_WRITE),
        .count   (state_q == ST_GAP),
        .expire  (gap_expire)
    );

    assign busy           = (state_q != ST_IDLE);
    assign ioctl_download = (state_q != ST_IDLE);
    assign ioctl_wr       = (state_q == ST_WRITE);
    assign s_ready        = (state_q == ST_FETCH) && !ioctl_wait;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
    assign done           = done_q;
    assign cnt_inc        = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        index_d = index_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is also IDLE; a start landing on it is dropped.
                if (start && !done_q) begin
                    index_d = index;
                    len_d   = length;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = (len_q == '0) ? ST_TAIL : ST_FETCH;
            end
            ST_FETCH: begin
                if (s_valid && s_ready) begin
                    dout_d  = s_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_expire) begin
                    cnt_d = cnt_inc;
                    // Address only advances when another byte follows, so it
                    // never passes length-1 and cannot wrap at full length.
                    if (cnt_inc == len_q) begin
                        state_d = ST_TAIL;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_TAIL: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: there is no memory array here, so every flop takes the reset,
    // which also guarantees the all-zero outputs during reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ioctl_tx.sv
// Self-checking bench for ioctl_tx: table of whole transfers plus hand-written
// reset, restart and full-length sequences.
module tb_ioctl_tx;

    localparam int unsigned GAP    = 3;
    localparam int unsigned AW     = 25;
    localparam int          BUDGET = 400;

    typedef struct {
        string      name;
        logic [7:0] idx;
        int         len;
        bit         rnd;
        logic [23:0] head;
        int         wait_after;
        int         wait_len;
        int         exp_wr;
        int         exp_dl;
        int         exp_gap;
        int         exp_ready;
    } vec_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b1;
    logic          start;
    logic [7:0]    index;
    logic [AW-1:0] length;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ioctl_wait;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          busy;
    logic          done;

    logic          d2_start;
    logic [3:0]    d2_len;
    logic [7:0]    d2_sdata;
    logic          d2_ready;
    logic          d2_dl;
    logic          d2_wr;
    logic [3:0]    d2_addr;
    logic [7:0]    d2_dout;
    logic [7:0]    d2_index;
    logic          d2_busy;
    logic          d2_done;

    int n_vec = 0;
    int n_bad = 0;

    int            dl_cycles, done_cnt, ready_cnt, hs_cnt;
    int            busy_bad, ready_bad, wait_bad, index_bad, cyc;
    logic [AW-1:0] wr_addr [$];
    logic [7:0]    wr_data [$];
    int            wr_cyc  [$];
    logic [7:0]    src [16];
    int            src_len, src_ptr;
    bit            rnd_valid;
    logic [7:0]    lfsr;
    logic [7:0]    exp_index;
    vec_t          vecs [5];

    always #5 clk_sys = ~clk_sys;

    ioctl_tx #(.GAP_CYC(GAP), .AW(AW)) u_dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (start),
        .index          (index),
        .length         (length),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .ioctl_wait     (ioctl_wait),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .busy           (busy),
        .done           (done)
    );

    // Narrow, gapless instance: full-length transfer with no address wrap.
    ioctl_tx #(.GAP_CYC(0), .AW(4)) u_dut_wide (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (d2_start),
        .index          (8'h5C),
        .length         (d2_len),
        .s_data         (d2_sdata),
        .s_valid        (1'b1),
        .s_ready        (d2_ready),
        .ioctl_wait     (1'b0),
        .ioctl_download (d2_dl),
        .ioctl_wr       (d2_wr),
        .ioctl_addr     (d2_addr),
        .ioctl_dout     (d2_dout),
        .ioctl_index    (d2_index),
        .busy           (d2_busy),
        .done           (d2_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        dl_cycles = 0; done_cnt = 0; ready_cnt = 0; hs_cnt = 0;
        busy_bad = 0; ready_bad = 0; wait_bad = 0; index_bad = 0; cyc = 0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        src_ptr = 0; lfsr = 8'hB5;
    endtask

    task automatic fill_src(input logic [23:0] head);
        for (int k = 0; k < 16; k++) src[k] = 8'(32 + 13 * k);
        src[0] = head[23:16];
        src[1] = head[15:8];
        src[2] = head[7:0];
    endtask

    // One clock: drive source/back-pressure at the falling edge, then sample.
    task automatic step(input bit w);
        @(negedge clk_sys);
        ioctl_wait = w;
        s_valid = (src_ptr < src_len) && (!rnd_valid || lfsr[0]);
        s_data  = (src_ptr < src_len) ? src[src_ptr[3:0]] : 8'h00;
        #1;
        cyc++;
        if (ioctl_download) dl_cycles++;
        if (done) done_cnt++;
        if (s_ready) ready_cnt++;
        if (ioctl_wr) begin
            wr_addr.push_back(ioctl_addr);
            wr_data.push_back(ioctl_dout);
            wr_cyc.push_back(cyc);
        end
        if (busy !== ioctl_download) busy_bad++;
        if (s_ready && !ioctl_download) ready_bad++;
        if (ioctl_wait && (s_ready || ioctl_wr)) wait_bad++;
        if (ioctl_download && ioctl_index !== exp_index) index_bad++;
        if (s_valid && s_ready) begin
            hs_cnt++;
            src_ptr++;
        end
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    endtask

    task automatic run_vec(input vec_t v);
        bit seen, used;
        int wait_left;
        clear_mon();
        exp_index = v.idx;
        rnd_valid = v.rnd;
        src_len   = v.len;
        fill_src(v.head);
        start  = 1'b1;
        index  = v.idx;
        length = AW'(v.len);
        step(1'b0);
        start  = 1'b0;
        index  = ~v.idx;
        length = AW'(v.len + 5);
        seen = 1'b0; used = 1'b0; wait_left = 0;
        if (done_cnt > 0) seen = 1'b1;
        for (int c = 0; c < BUDGET && !seen; c++) begin
            if (v.wait_after > 0 && !used && wr_addr.size() == v.wait_after) begin
                used = 1'b1;
                wait_left = v.wait_len;
            end
            step(wait_left > 0);
            if (wait_left > 0) wait_left--;
            if (done_cnt > 0) seen = 1'b1;
        end
        repeat (4) step(1'b0);
        check({v.name, " finished"}, seen, 1);
        check({v.name, " done pulses"}, done_cnt, 1);
        check({v.name, " wr count"}, wr_addr.size(), v.exp_wr);
        check({v.name, " handshakes"}, hs_cnt, v.len);
        if (v.exp_dl >= 0) check({v.name, " download cycles"}, dl_cycles, v.exp_dl);
        if (v.exp_ready >= 0) check({v.name, " s_ready cycles"}, ready_cnt, v.exp_ready);
        for (int k = 0; k < wr_addr.size() && k < v.len; k++) begin
            check($sformatf("%s addr[%0d]", v.name, k), wr_addr[k], k);
            check($sformatf("%s data[%0d]", v.name, k), wr_data[k], src[k]);
            if (v.exp_gap > 0 && k > 0)
                check($sformatf("%s spacing[%0d]", v.name, k), wr_cyc[k] - wr_cyc[k-1], v.exp_gap);
        end
        check({v.name, " busy vs download"}, busy_bad, 0);
        check({v.name, " s_ready outside window"}, ready_bad, 0);
        check({v.name, " activity under wait"}, wait_bad, 0);
        check({v.name, " index stability"}, index_bad, 0);
        check({v.name, " index after"}, ioctl_index, v.idx);
        if (v.len > 0) check({v.name, " final addr"}, ioctl_addr, v.len - 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ioctl_download"}, ioctl_download, 0);
        check({tag, " ioctl_wr"}, ioctl_wr, 0);
        check({tag, " s_ready"}, s_ready, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " ioctl_addr"}, ioctl_addr, 0);
        check({tag, " ioctl_dout"}, ioctl_dout, 0);
        check({tag, " ioctl_index"}, ioctl_index, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int d2_ptr, n2, dl2;

        start = 1'b0; index = '0; length = '0;
        s_valid = 1'b0; s_data = '0; ioctl_wait = 1'b0;
        d2_start = 1'b0; d2_len = 4'hF; d2_sdata = '0;
        clear_mon();
        exp_index = '0; rnd_valid = 1'b0; src_len = 0;

        #1 reset_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        check("reset wide busy", d2_busy, 0);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;

        vecs[0] = '{name:"basic", idx:8'h03, len:4, rnd:1'b0, head:24'h112233,
                    wait_after:0, wait_len:0, exp_wr:4, exp_dl:22, exp_gap:5, exp_ready:4};
        vecs[1] = '{name:"empty", idx:8'h81, len:0, rnd:1'b0, head:24'h000000,
                    wait_after:0, wait_len:0, exp_wr:0, exp_dl:2, exp_gap:0, exp_ready:0};
        vecs[2] = '{name:"backpressure", idx:8'h42, len:4, rnd:1'b0, head:24'hC3D4E5,
                    wait_after:2, wait_len:13, exp_wr:4, exp_dl:32, exp_gap:0, exp_ready:4};
        vecs[3] = '{name:"sparse valid", idx:8'hC7, len:3, rnd:1'b1, head:24'hA55AFF,
                    wait_after:0, wait_len:0, exp_wr:3, exp_dl:-1, exp_gap:0, exp_ready:-1};
        vecs[4] = '{name:"single", idx:8'hFF, len:1, rnd:1'b0, head:24'h7E0000,
                    wait_after:0, wait_len:0, exp_wr:1, exp_dl:7, exp_gap:0, exp_ready:1};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort a length-8 transfer just after its second write.
        clear_mon();
        exp_index = 8'h6E; rnd_valid = 1'b0; src_len = 8;
        fill_src(24'h909192);
        start = 1'b1; index = 8'h6E; length = AW'(8);
        step(1'b0);
        start = 1'b0;
        for (int c = 0; c < BUDGET && wr_addr.size() < 2; c++) step(1'b0);
        check("abort reached second write", wr_addr.size(), 2);
        step(1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        clear_mon();
        src_len = 0;
        repeat (20) step(1'b0);
        check("abort no done", done_cnt, 0);
        check("abort no wr", wr_addr.size(), 0);
        check("abort stays idle", dl_cycles, 0);
        vecs[0].name = "after abort";
        run_vec(vecs[0]);

        // Start held high through the whole transfer and its done cycle.
        clear_mon();
        exp_index = 8'h11; rnd_valid = 1'b0; src_len = 2;
        fill_src(24'h2B3C4D);
        start = 1'b1; index = 8'h11; length = AW'(2);
        step(1'b0);
        index = 8'h99; length = AW'(5);
        seen = 1'b0;
        for (int c = 0; c < BUDGET && !seen; c++) begin
            step(1'b0);
            if (done_cnt > 0) seen = 1'b1;
        end
        start = 1'b0;
        repeat (20) step(1'b0);
        check("restart done pulses", done_cnt, 1);
        check("restart wr count", wr_addr.size(), 2);
        check("restart download cycles", dl_cycles, 12);
        check("restart index stability", index_bad, 0);
        check("restart index after", ioctl_index, 8'h11);
        check("restart final addr", ioctl_addr, 1);
        check("restart idle after", busy, 0);

        // Full-length transfer on the 4-bit address instance with zero gap.
        d2_ptr = 0; n2 = 0; dl2 = 0; seen = 1'b0;
        @(negedge clk_sys);
        d2_start = 1'b1;
        @(negedge clk_sys);
        d2_start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            d2_sdata = 8'(8'h40 + d2_ptr);
            #1;
            if (d2_dl) dl2++;
            if (d2_wr) begin
                check($sformatf("wide addr[%0d]", n2), d2_addr, n2);
                check($sformatf("wide data[%0d]", n2), d2_dout, 8'(8'h40 + n2));
                n2++;
            end
            if (d2_ready) d2_ptr++;
            if (d2_done) seen = 1'b1;
            @(negedge clk_sys);
        end
        check("wide finished", seen, 1);
        check("wide wr count", n2, 15);
        check("wide download cycles", dl2, 47);
        check("wide final addr", d2_addr, 4'hE);
        check("wide index", d2_index, 8'h5C);
        check("wide busy after", d2_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
